// File: rtl/terminal_bank_if.sv
// Handshake and per-row terminal bus between the clause array edge, the
// terminal bank and the BCP controller.
interface terminal_bank_if #(
    parameter int NUM_C       = 8,
    parameter int WIDTH_LVL   = 16,
    parameter int WIDTH_C_LEN = 4,
    parameter int WIDTH_CID   = 3,
    parameter int WIDTH_CNT   = 4
);
    logic                         start_i;
    logic                         ack_i;
    logic [NUM_C-1:0]             csat_i;
    logic [2*NUM_C-1:0]           freelitcnt_i;
    logic [NUM_C*WIDTH_C_LEN-1:0] clause_len_i;
    logic [NUM_C-1:0]             conflict_c_i;
    logic [NUM_C-1:0]             all_lit_false_i;
    logic [NUM_C*WIDTH_LVL-1:0]   cmax_lvl_i;

    logic [NUM_C-1:0]             csat_drv_o;
    logic [NUM_C-1:0]             imp_drv_o;
    logic [NUM_C-1:0]             conflict_c_drv_o;
    logic                         done_o;
    logic                         conflict_o;
    logic [WIDTH_CID-1:0]         conflict_cid_o;
    logic [WIDTH_LVL-1:0]         conflict_lvl_o;
    logic [WIDTH_LVL-1:0]         conflict_max_lvl_o;
    logic [WIDTH_CNT-1:0]         imp_cnt_o;
    logic                         all_sat_o;

    modport master (
        output start_i, ack_i, csat_i, freelitcnt_i, clause_len_i,
               conflict_c_i, all_lit_false_i, cmax_lvl_i,
        input  csat_drv_o, imp_drv_o, conflict_c_drv_o, done_o, conflict_o,
               conflict_cid_o, conflict_lvl_o, conflict_max_lvl_o,
               imp_cnt_o, all_sat_o
    );

    modport slave (
        input  start_i, ack_i, csat_i, freelitcnt_i, clause_len_i,
               conflict_c_i, all_lit_false_i, cmax_lvl_i,
        output csat_drv_o, imp_drv_o, conflict_c_drv_o, done_o, conflict_o,
               conflict_cid_o, conflict_lvl_o, conflict_max_lvl_o,
               imp_cnt_o, all_sat_o
    );
endinterface

// File: rtl/terminal_bank.sv
// Snapshots NUM_C clause terminal rows, drives per-row sat/imp/conflict lines
// from the snapshot and serially summarises them under a done/ack handshake.
module terminal_bank #(
    parameter int NUM_C       = 8,
    parameter int WIDTH_LVL   = 16,
    parameter int WIDTH_C_LEN = 4,
    parameter int WIDTH_CID   = 3,
    parameter int WIDTH_CNT   = 4
) (
    input logic             clk,
    input logic             rst,
    terminal_bank_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [WIDTH_CNT-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH_CID-1:0] LAST_IDX = WIDTH_CID'(NUM_C - 1);

    state_t state, state_nxt;

    logic [NUM_C-1:0]             snap_csat;
    logic [2*NUM_C-1:0]           snap_flc;
    logic [NUM_C*WIDTH_C_LEN-1:0] snap_len;
    logic [NUM_C-1:0]             snap_cc;
    logic [NUM_C-1:0]             snap_alf;
    logic [NUM_C*WIDTH_LVL-1:0]   snap_cmax;

    logic [WIDTH_CID-1:0] idx;

    logic                 acc_conflict, acc_conflict_nxt;
    logic [WIDTH_CID-1:0] acc_cid,      acc_cid_nxt;
    logic [WIDTH_LVL-1:0] acc_lvl,      acc_lvl_nxt;
    logic [WIDTH_LVL-1:0] acc_max,      acc_max_nxt;
    logic [WIDTH_CNT-1:0] acc_cnt,      acc_cnt_nxt;
    logic                 acc_all_sat,  acc_all_sat_nxt;

    logic [NUM_C-1:0]     imp_drv, conflict_drv;
    logic [WIDTH_LVL-1:0] row_lvl;
    logic                 row_c, row_len_nz, row_qual;
    logic                 take;

    // A new snapshot is accepted from IDLE, or from DONE only together with ack.
    assign take = bus.start_i && (state == IDLE || (state == DONE && bus.ack_i));

    // ---------------- FSM: state register ----------------
    // NOTE: reset here is synchronous, so it sits inside the clocked branch
    // rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every variable assigned in a combinational block gets a default
    // first, otherwise an uncovered path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start_i) state_nxt = SCAN;
            SCAN: if (idx == LAST_IDX) state_nxt = DONE;
            DONE: if (bus.ack_i) state_nxt = bus.start_i ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.done_o = (state == DONE);
    end

    // Per-row drive lines come from the snapshot only, never from live inputs.
    always_comb begin
        imp_drv      = '0;
        conflict_drv = '0;
        for (int k = 0; k < NUM_C; k++) begin
            imp_drv[k]      = (snap_flc[2*k +: 2] == 2'd1);
            conflict_drv[k] = snap_cc[k] |
                              (snap_alf[k] & (snap_len[k*WIDTH_C_LEN +: WIDTH_C_LEN] != '0));
        end
    end

    assign bus.csat_drv_o       = snap_csat;
    assign bus.imp_drv_o        = imp_drv;
    assign bus.conflict_c_drv_o = conflict_drv;

    // Contribution of the row currently under the scan pointer.
    always_comb begin
        row_c      = conflict_drv[idx];
        row_lvl    = snap_cmax[idx*WIDTH_LVL +: WIDTH_LVL];
        row_len_nz = (snap_len[idx*WIDTH_C_LEN +: WIDTH_C_LEN] != '0);
        row_qual   = imp_drv[idx] & ~snap_csat[idx] & ~row_c & row_len_nz;
    end

    always_comb begin
        acc_conflict_nxt = acc_conflict;
        acc_cid_nxt      = acc_cid;
        acc_lvl_nxt      = acc_lvl;
        acc_max_nxt      = acc_max;
        acc_cnt_nxt      = acc_cnt;
        acc_all_sat_nxt  = acc_all_sat;
        if (row_c && !acc_conflict) begin
            acc_conflict_nxt = 1'b1;
            acc_cid_nxt      = idx;
            acc_lvl_nxt      = row_lvl;
        end
        if (row_c && row_lvl > acc_max) acc_max_nxt = row_lvl;
        if (row_qual && acc_cnt != CNT_MAX) acc_cnt_nxt = acc_cnt + WIDTH_CNT'(1);
        if (row_len_nz && !snap_csat[idx]) acc_all_sat_nxt = 1'b0;
    end

    // ---------------- datapath: snapshot, accumulators, results ----------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_csat              <= '0;
            snap_flc               <= '0;
            snap_len               <= '0;
            snap_cc                <= '0;
            snap_alf               <= '0;
            snap_cmax              <= '0;
            idx                    <= '0;
            acc_conflict           <= 1'b0;
            acc_cid                <= '0;
            acc_lvl                <= '0;
            acc_max                <= '0;
            acc_cnt                <= '0;
            acc_all_sat            <= 1'b0;
            bus.conflict_o         <= 1'b0;
            bus.conflict_cid_o     <= '0;
            bus.conflict_lvl_o     <= '0;
            bus.conflict_max_lvl_o <= '0;
            bus.imp_cnt_o          <= '0;
            bus.all_sat_o          <= 1'b0;
        end else if (take) begin
            snap_csat    <= bus.csat_i;
            snap_flc     <= bus.freelitcnt_i;
            snap_len     <= bus.clause_len_i;
            snap_cc      <= bus.conflict_c_i;
            snap_alf     <= bus.all_lit_false_i;
            snap_cmax    <= bus.cmax_lvl_i;
            idx          <= '0;
            acc_conflict <= 1'b0;
            acc_cid      <= '0;
            acc_lvl      <= '0;
            acc_max      <= '0;
            acc_cnt      <= '0;
            acc_all_sat  <= 1'b1;
        end else if (state == SCAN) begin
            idx          <= idx + WIDTH_CID'(1);
            acc_conflict <= acc_conflict_nxt;
            acc_cid      <= acc_cid_nxt;
            acc_lvl      <= acc_lvl_nxt;
            acc_max      <= acc_max_nxt;
            acc_cnt      <= acc_cnt_nxt;
            acc_all_sat  <= acc_all_sat_nxt;
            // Results include the last row and then hold until the next DONE entry.
            if (idx == LAST_IDX) begin
                bus.conflict_o         <= acc_conflict_nxt;
                bus.conflict_cid_o     <= acc_cid_nxt;
                bus.conflict_lvl_o     <= acc_lvl_nxt;
                bus.conflict_max_lvl_o <= acc_max_nxt;
                bus.imp_cnt_o          <= acc_cnt_nxt;
                bus.all_sat_o          <= acc_all_sat_nxt;
            end
        end
    end
endmodule

// File: tb/tb_terminal_bank.sv
// Directed bench for terminal_bank: a transaction-level model checked every
// cycle plus hand-computed expectations for the documented scenarios.
module tb_terminal_bank;
    localparam int NC  = 8;
    localparam int LW  = 16;
    localparam int CLW = 4;
    localparam int IW  = 3;
    localparam int CW  = 4;

    typedef struct packed {
        logic          conflict;
        logic [IW-1:0] cid;
        logic [LW-1:0] lvl;
        logic [LW-1:0] maxlvl;
        logic [CW-1:0] cnt;
        logic          all_sat;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    terminal_bank_if #(.NUM_C(NC), .WIDTH_LVL(LW), .WIDTH_C_LEN(CLW),
                       .WIDTH_CID(IW), .WIDTH_CNT(CW)) bus ();

    terminal_bank #(.NUM_C(NC), .WIDTH_LVL(LW), .WIDTH_C_LEN(CLW),
                    .WIDTH_CID(IW), .WIDTH_CNT(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic res_t summarize(input logic [NC-1:0] csat, input logic [2*NC-1:0] flc,
                                       input logic [NC*CLW-1:0] len, input logic [NC-1:0] cc,
                                       input logic [NC-1:0] alf, input logic [NC*LW-1:0] cmax);
        res_t r;
        int   n = 0;
        r = '0;
        r.all_sat = 1'b1;
        for (int k = 0; k < NC; k++) begin
            bit          live  = (len[k*CLW +: CLW] != 0);
            bit          conf  = cc[k] || (alf[k] && live);
            int unsigned level = cmax[k*LW +: LW];
            if (conf && !r.conflict) begin
                r.conflict = 1'b1;
                r.cid      = IW'(k);
                r.lvl      = LW'(level);
            end
            if (conf && level > r.maxlvl) r.maxlvl = LW'(level);
            if (flc[2*k +: 2] == 1 && !csat[k] && !conf && live) n++;
            if (live && !csat[k]) r.all_sat = 1'b0;
        end
        r.cnt = (n > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(n);
        return r;
    endfunction

    function automatic logic [NC-1:0] imp_of(input logic [2*NC-1:0] flc);
        logic [NC-1:0] v = '0;
        for (int k = 0; k < NC; k++) v[k] = (flc[2*k +: 2] == 1);
        return v;
    endfunction

    function automatic logic [NC-1:0] conf_of(input logic [NC-1:0] cc, input logic [NC-1:0] alf,
                                              input logic [NC*CLW-1:0] len);
        logic [NC-1:0] v = '0;
        for (int k = 0; k < NC; k++) v[k] = cc[k] || (alf[k] && len[k*CLW +: CLW] != 0);
        return v;
    endfunction

    logic [NC-1:0]     s_csat, s_cc, s_alf;
    logic [2*NC-1:0]   s_flc;
    logic [NC*CLW-1:0] s_len;
    res_t              m_pend, m_res;
    int                m_left;
    bit                m_done;

    // Transaction view: a run lasts NC edges after the start edge, then a result is shown.
    always @(posedge clk) begin
        if (!rst) begin
            s_csat <= '0; s_cc <= '0; s_alf <= '0; s_flc <= '0; s_len <= '0;
            m_res  <= '0; m_pend <= '0; m_left <= 0; m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else if (bus.start_i && (!m_done || bus.ack_i)) begin
            s_csat <= bus.csat_i;        s_cc  <= bus.conflict_c_i;
            s_alf  <= bus.all_lit_false_i; s_flc <= bus.freelitcnt_i;
            s_len  <= bus.clause_len_i;
            m_pend <= summarize(bus.csat_i, bus.freelitcnt_i, bus.clause_len_i,
                                bus.conflict_c_i, bus.all_lit_false_i, bus.cmax_lvl_i);
            m_left <= NC;
            m_done <= 1'b0;
        end else if (m_done && bus.ack_i) begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("csat_drv", 32'(bus.csat_drv_o), 32'(s_csat));
            check("imp_drv", 32'(bus.imp_drv_o), 32'(imp_of(s_flc)));
            check("conflict_drv", 32'(bus.conflict_c_drv_o), 32'(conf_of(s_cc, s_alf, s_len)));
            check("done", 32'(bus.done_o), 32'(m_done));
            check("conflict", 32'(bus.conflict_o), 32'(m_res.conflict));
            check("cid", 32'(bus.conflict_cid_o), 32'(m_res.cid));
            check("lvl", 32'(bus.conflict_lvl_o), 32'(m_res.lvl));
            check("maxlvl", 32'(bus.conflict_max_lvl_o), 32'(m_res.maxlvl));
            check("imp_cnt", 32'(bus.imp_cnt_o), 32'(m_res.cnt));
            check("all_sat", 32'(bus.all_sat_o), 32'(m_res.all_sat));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_row(input int k, input bit csat, input logic [1:0] flc, input int len,
                           input bit cc, input bit alf, input int cmax);
        bus.csat_i[k]                 = csat;
        bus.freelitcnt_i[2*k +: 2]    = flc;
        bus.clause_len_i[k*CLW +: CLW] = CLW'(len);
        bus.conflict_c_i[k]           = cc;
        bus.all_lit_false_i[k]        = alf;
        bus.cmax_lvl_i[k*LW +: LW]    = LW'(cmax);
    endtask

    task automatic pattern_a;
        for (int k = 0; k < NC; k++) set_row(k, 1'b0, 2'd2, 3, 1'b0, 1'b0, k);
        set_row(2, 1'b0, 2'd2, 3, 1'b1, 1'b0, 7);
        set_row(5, 1'b0, 2'd2, 3, 1'b1, 1'b0, 12);
        set_row(6, 1'b0, 2'd2, 0, 1'b0, 1'b1, 6);
    endtask

    task automatic pattern_b;
        for (int k = 0; k < NC; k++) set_row(k, 1'b1, 2'd2, 3, 1'b0, 1'b0, 20 + k);
        set_row(3, 1'b0, 2'd2, 0, 1'b0, 1'b0, 23);
    endtask

    task automatic pattern_c;
        for (int k = 0; k < NC; k++) set_row(k, 1'b0, 2'd2, 2, 1'b0, 1'b0, k);
        set_row(0, 1'b0, 2'd1, 2, 1'b0, 1'b0, 0);
        set_row(1, 1'b1, 2'd1, 2, 1'b0, 1'b0, 1);
        set_row(4, 1'b0, 2'd1, 2, 1'b0, 1'b0, 4);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.done_o && n < budget) begin
            step(1);
            n++;
        end
        check("wait_done", 32'(bus.done_o), 32'd1);
    endtask

    task automatic pulse_ack;
        bus.ack_i = 1'b1;
        step(1);
        bus.ack_i = 1'b0;
    endtask

    task automatic check_a_result;
        check("A_conflict", 32'(bus.conflict_o), 32'd1);
        check("A_cid", 32'(bus.conflict_cid_o), 32'd2);
        check("A_lvl", 32'(bus.conflict_lvl_o), 32'd7);
        check("A_maxlvl", 32'(bus.conflict_max_lvl_o), 32'd12);
        check("A_conf_drv", 32'(bus.conflict_c_drv_o), 32'b0010_0100);
    endtask

    initial begin
        bus.start_i = 1'b0; bus.ack_i = 1'b0;
        bus.csat_i = '0; bus.freelitcnt_i = '0; bus.clause_len_i = '0;
        bus.conflict_c_i = '0; bus.all_lit_false_i = '0; bus.cmax_lvl_i = '0;
        step(2);
        cmp_en = 1'b1;
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_all_sat", 32'(bus.all_sat_o), 32'd0);
        check("rst_csat_drv", 32'(bus.csat_drv_o), 32'd0);
        rst = 1'b1;

        // Scenario A with start held: exact latency, frozen snapshot, start ignored in DONE.
        pattern_a();
        bus.start_i = 1'b1;
        step(1);
        step(7);
        check("A_not_yet_done", 32'(bus.done_o), 32'd0);
        for (int k = 0; k < NC; k++) set_row(k, 1'b1, 2'd1, 5, 1'b0, 1'b0, 99);
        step(1);
        check("A_done_at_e8", 32'(bus.done_o), 32'd1);
        check_a_result();
        check("A_imp_cnt", 32'(bus.imp_cnt_o), 32'd0);
        step(3);
        check("A_start_no_ack", 32'(bus.done_o), 32'd1);
        check("A_cid_held", 32'(bus.conflict_cid_o), 32'd2);

        // Scenario B via ack+start back-to-back.
        pattern_b();
        bus.ack_i = 1'b1;
        step(1);
        bus.ack_i = 1'b0;
        bus.start_i = 1'b0;
        check("B_done_dropped", 32'(bus.done_o), 32'd0);
        step(7);
        check("B_not_yet_done", 32'(bus.done_o), 32'd0);
        step(1);
        check("B_done", 32'(bus.done_o), 32'd1);
        check("B_all_sat", 32'(bus.all_sat_o), 32'd1);
        check("B_conflict", 32'(bus.conflict_o), 32'd0);
        check("B_imp_cnt", 32'(bus.imp_cnt_o), 32'd0);
        pulse_ack();
        check("B_idle_done", 32'(bus.done_o), 32'd0);
        check("B_idle_hold", 32'(bus.all_sat_o), 32'd1);

        // Scenario C: implication count.
        pattern_c();
        bus.start_i = 1'b1;
        step(1);
        bus.start_i = 1'b0;
        wait_done(20);
        check("C_imp_drv", 32'(bus.imp_drv_o), 32'b0001_0011);
        check("C_imp_cnt", 32'(bus.imp_cnt_o), 32'd2);
        check("C_all_sat", 32'(bus.all_sat_o), 32'd0);
        pulse_ack();

        // Reset in the middle of a scan aborts it and clears everything.
        pattern_a();
        bus.start_i = 1'b1;
        step(1);
        bus.start_i = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        check("R_done", 32'(bus.done_o), 32'd0);
        check("R_csat_drv", 32'(bus.csat_drv_o), 32'd0);
        check("R_imp_drv", 32'(bus.imp_drv_o), 32'd0);
        check("R_conf_drv", 32'(bus.conflict_c_drv_o), 32'd0);
        check("R_imp_cnt", 32'(bus.imp_cnt_o), 32'd0);
        check("R_all_sat", 32'(bus.all_sat_o), 32'd0);
        step(10);
        check("R_no_late_done", 32'(bus.done_o), 32'd0);
        bus.start_i = 1'b1;
        step(1);
        bus.start_i = 1'b0;
        wait_done(20);
        check_a_result();
        pulse_ack();

        // A few mixed patterns, checked by the model only.
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < NC; k++)
                set_row(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
                        1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 65535)));
            bus.start_i = 1'b1;
            step(1);
            bus.start_i = 1'b0;
            wait_done(20);
            step(2);
            pulse_ack();
        end

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/terminal_bank.md
# terminal_bank

Registered, multi-clause successor to the per-clause terminal cell. It sits at the right-hand edge of the clause array. On request it snapshots the terminal signals of `NUM_C` clause rows and drives the per-clause sat/implication/conflict lines from that snapshot. It then scans the rows serially to produce one summarised result (first conflict, its level, the maximum conflict level, implication count and all-satisfied), which it holds under a done/ack handshake for the BCP controller.

## Interface
- `NUM_C`, 8: number of clause rows handled.
- `WIDTH_LVL`, 16: decision-level width.
- `WIDTH_C_LEN`, 4: clause-length field width.
- `WIDTH_CID`, 3: clause-index width; must be ≥ clog2(`NUM_C`).
- `WIDTH_CNT`, 4: implication-count width; must be ≥ clog2(`NUM_C`+1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `start_i` in 1: snapshot inputs and begin a scan.
- `ack_i` in 1: result consumed.
- `csat_i` in `NUM_C`: clause satisfied, one bit per row.
- `freelitcnt_i` in 2·`NUM_C`: free-literal count per row, saturating at 2; row k occupies bits [2k+1:2k].
- `clause_len_i` in `NUM_C`·`WIDTH_C_LEN`: length per row; 0 marks an empty slot.
- `conflict_c_i` in `NUM_C`: upstream conflict per row.
- `all_lit_false_i` in `NUM_C`: every literal of the row is false.
- `cmax_lvl_i` in `NUM_C`·`WIDTH_LVL`: max literal level per row.
- `csat_drv_o` out `NUM_C`: snapshot csat.
- `imp_drv_o` out `NUM_C`: snapshot freelitcnt==1.
- `conflict_c_drv_o` out `NUM_C`: snapshot conflict_c | (all_lit_false & len≠0).
- `done_o` out 1: result valid; level signal, not a pulse.
- `conflict_o` out 1: at least one row conflicts.
- `conflict_cid_o` out `WIDTH_CID`: lowest conflicting row index.
- `conflict_lvl_o` out `WIDTH_LVL`: cmax_lvl of that row.
- `conflict_max_lvl_o` out `WIDTH_LVL`: maximum cmax_lvl over all conflicting rows.
- `imp_cnt_o` out `WIDTH_CNT`: number of rows with imp_drv & ~csat_drv & ~conflict_c_drv & len≠0.
- `all_sat_o` out 1: every row with len≠0 has csat.

## Operation
- The FSM has three states: IDLE, SCAN and DONE.
- **IDLE**
  - On `start_i`, all inputs are captured into snapshot registers, `idx`←0 and all accumulators are cleared: conflict=0, cid=0, lvl=0, maxlvl=0, cnt=0, all_sat=1.
  - The state then moves to SCAN.
- **SCAN**, one row per cycle at row `idx`:
  - Derive c = conflict_c_drv[`idx`].
  - If c and no conflict has been recorded yet, record cid=`idx` and lvl=cmax[`idx`].
  - If c and cmax[`idx`] > maxlvl, set maxlvl=cmax[`idx`].
  - If the row qualifies, increment cnt (saturating at its maximum value).
  - If len≠0 and ~csat, clear all_sat.
  - `idx` increments each cycle. On the cycle with `idx`==`NUM_C`-1 the state moves to DONE and the result registers load the final accumulator values, including that row's contribution.
  - `start_i` is ignored during SCAN.
- **DONE**
  - `done_o`=1 and the result outputs are stable.
  - `ack_i` alone returns the FSM to IDLE.
  - `ack_i` together with `start_i` takes a new snapshot and goes directly to SCAN.
  - `start_i` without `ack_i` is ignored.
- The per-row drive outputs are combinational from the snapshot registers only, never from live inputs. They change only at snapshot edges.
- Level comparisons are unsigned.
- Empty rows (len==0) never conflict through `all_lit_false` and never count toward implications or all_sat. A set `conflict_c_i` on an empty row still propagates.

## Timing
- Reset, or `rst`=0 at any edge including mid-SCAN or DONE, produces:
  - state IDLE, snapshot registers 0, and therefore all `*_drv_o`=0;
  - `done_o`=0, `conflict_o`=0, `conflict_cid_o`=0, `conflict_lvl_o`=0, `conflict_max_lvl_o`=0, `imp_cnt_o`=0 and `all_sat_o`=0;
  - any in-flight scan is aborted with no done.
- Let E0 be the edge that samples `start_i`.
  - The drive outputs reflect the snapshot from E0 onward.
  - `done_o` rises after edge E0+`NUM_C`, so latency is `NUM_C` cycles.
- Result outputs are updated only on entry to DONE and hold their values through IDLE until the next DONE entry.
- `done_o` falls on the edge after the cycle in which `ack_i` is sampled.
- Back-to-back operation with start and ack in the same cycle gives a throughput of one result per `NUM_C`+1 cycles.

## Test plan
- Reset mid-SCAN (`rst`=0 at cycle 3 of 8) → next cycle: `done_o`=0, all drives 0, all results 0; a later start completes normally.
- `NUM_C`=8, rows 2 and 5 conflicting with cmax 7 and 12, row 6 with len=0 and all_lit_false=1 → `conflict_o`=1, cid=2, lvl=7, maxlvl=12; `conflict_c_drv_o`[6]=0.
- All rows csat=1 except row 3 with len=0 and csat=0 → `all_sat_o`=1, `conflict_o`=0, `imp_cnt_o`=0.
- freelitcnt=1 on rows 0, 1 and 4, with row 1 csat=1 → `imp_drv_o`=8'b00010011, `imp_cnt_o`=2.
- `start_i` held from E0 → `done_o` high after exactly E0+8. Inputs changed during SCAN → drives and results unchanged. `start_i` in DONE without `ack_i` → ignored. `start_i` with `ack_i` → next done after 8 more edges with the new data.
